// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// A grant lasts until the producer's last word, MAX_BURST words, or the producer drops valid.
module fifo_wr_arb #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  full_flag,
  output logic                  wr_en,
  output logic [WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [BW-1:0]   beats, beats_nxt, beats_inc;
  logic [PW-1:0]   pick, scan_idx;
  logic            found;
  logic            owner_valid, xfer, release_now;
  logic [WIDTH-1:0] lanes [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lanes[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Walk the requesters starting at rr_ptr; the first valid one wins.
  always_comb begin
    pick     = rr_ptr;
    found    = 1'b0;
    scan_idx = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
      scan_idx = (scan_idx == PW'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  assign busy        = (state == BURST);
  assign owner_valid = req_valid[owner];
  assign xfer        = busy && owner_valid && !full_flag;
  assign beats_inc   = beats + 1'b1;
  assign release_now = busy && (!owner_valid ||
                       (xfer && (req_last[owner] || beats_inc == BW'(MAX_BURST))));

  assign req_ready = (busy && !full_flag) ? grant : '0;
  assign wr_en     = xfer;
  assign wdata     = xfer ? lanes[owner] : '0;

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    beats_nxt  = beats;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = BURST;
          owner_nxt = pick;
          grant_nxt = NREQ'(1) << pick;
          beats_nxt = '0;
        end
      end
      BURST: begin
        if (release_now) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          grant_nxt  = '0;
          beats_nxt  = '0;
        end else if (xfer) begin
          beats_nxt = beats_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= '0;
      grant  <= '0;
      rr_ptr <= '0;
      beats  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
      beats  <= beats_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: a cycle-by-cycle vector table plus hand-written
// sequences for mid-burst reset and sustained round-robin bursts.
module tb_fifo_wr_arb;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  full_flag;
  logic                  wr_en;
  logic [WIDTH-1:0]      wdata;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  logic [27:0] word_cnt;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [27:0] word;
    logic [3:0]  exp_grant;
    logic        exp_busy;
    logic        exp_wr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_ready;
  } vec_t;

  vec_t vecs[$];

  fifo_wr_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .full_flag(full_flag),
    .wr_en(wr_en), .wdata(wdata), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic r, input logic [3:0] v,
                              input logic [3:0] l, input logic f, input logic [27:0] w,
                              input logic [3:0] eg, input logic eb, input logic ew,
                              input logic [31:0] ed, input logic [3:0] er);
    vec_t x;
    x.name = n; x.rst = r; x.valid = v; x.last = l; x.full = f; x.word = w;
    x.exp_grant = eg; x.exp_busy = eb; x.exp_wr = ew; x.exp_wdata = ed; x.exp_ready = er;
    return x;
  endfunction

  // Lane i carries {i, word} so the written value identifies its producer.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] l,
                               input logic f, input logic [27:0] w);
    rst       = r;
    req_valid = v;
    req_last  = l;
    full_flag = f;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*WIDTH +: WIDTH] = {4'(i), w};
    end
  endtask

  task automatic checkOne(input string n, input string field, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h expected %h", n, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string n, input logic [3:0] eg, input logic eb,
                             input logic ew, input logic [31:0] ed, input logic [3:0] er);
    checkOne(n, "grant", 32'(grant), 32'(eg));
    checkOne(n, "busy", 32'(busy), 32'(eb));
    checkOne(n, "wr_en", 32'(wr_en), 32'(ew));
    checkOne(n, "wdata", wdata, ed);
    checkOne(n, "req_ready", 32'(req_ready), 32'(er));
  endtask

  task automatic step(input string n, input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic f, input logic [27:0] w, input logic [3:0] eg,
                      input logic eb, input logic ew, input logic [31:0] ed,
                      input logic [3:0] er);
    @(negedge clk);
    applyStimulus(r, v, l, f, w);
    #1;
    checkOutput(n, eg, eb, ew, ed, er);
  endtask

  initial begin
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 28'h0);

    // reset with everyone requesting, then requester 0 wins
    vecs.push_back(mk("rst_hold1",   0, 4'b1111, 4'b0000, 0, 28'h1, 4'b0000, 0, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("rst_hold2",   0, 4'b1111, 4'b0000, 0, 28'h1, 4'b0000, 0, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("rst_release", 1, 4'b1111, 4'b1111, 0, 28'h1, 4'b0000, 0, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("first_grant", 1, 4'b1111, 4'b1111, 0, 28'h1, 4'b0001, 1, 1, 32'h0000_0001, 4'b0001));
    vecs.push_back(mk("idle_a",      1, 4'b0000, 4'b0000, 0, 28'h0, 4'b0000, 0, 0, 32'h0, 4'b0000));
    // single producer 2, three words ending with last
    vecs.push_back(mk("sp_idle",     1, 4'b0100, 4'b0000, 0, 28'h1, 4'b0000, 0, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("sp_w1",       1, 4'b0100, 4'b0000, 0, 28'h1, 4'b0100, 1, 1, 32'h2000_0001, 4'b0100));
    vecs.push_back(mk("sp_w2",       1, 4'b0100, 4'b0000, 0, 28'h2, 4'b0100, 1, 1, 32'h2000_0002, 4'b0100));
    vecs.push_back(mk("sp_w3",       1, 4'b0100, 4'b0100, 0, 28'h3, 4'b0100, 1, 1, 32'h2000_0003, 4'b0100));
    vecs.push_back(mk("sp_released", 1, 4'b1001, 4'b0000, 0, 28'h5, 4'b0000, 0, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("rr_ptr_is3",  1, 4'b1001, 4'b1000, 0, 28'h5, 4'b1000, 1, 1, 32'h3000_0005, 4'b1000));
    vecs.push_back(mk("idle_b",      1, 4'b0000, 4'b0000, 0, 28'h0, 4'b0000, 0, 0, 32'h0, 4'b0000));
    // producer 3 drops valid after one word; waiting producer 0 goes next
    vecs.push_back(mk("drop_idle",   1, 4'b1000, 4'b0000, 0, 28'h6, 4'b0000, 0, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("drop_w1",     1, 4'b1001, 4'b0000, 0, 28'h6, 4'b1000, 1, 1, 32'h3000_0006, 4'b1000));
    vecs.push_back(mk("drop_rel",    1, 4'b0001, 4'b0000, 0, 28'h7, 4'b1000, 1, 0, 32'h0, 4'b1000));
    vecs.push_back(mk("drop_idle2",  1, 4'b0001, 4'b0000, 0, 28'h7, 4'b0000, 0, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("drop_next0",  1, 4'b0001, 4'b0001, 0, 28'h8, 4'b0001, 1, 1, 32'h0000_0008, 4'b0001));
    vecs.push_back(mk("idle_c",      1, 4'b0000, 4'b0000, 0, 28'h0, 4'b0000, 0, 0, 32'h0, 4'b0000));
    // producer 1 against a FIFO holding 7 of 8: one write, stall, two reads, two writes
    vecs.push_back(mk("bp_idle",     1, 4'b0010, 4'b0000, 0, 28'h9, 4'b0000, 0, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("bp_w1",       1, 4'b0010, 4'b0000, 0, 28'h9, 4'b0010, 1, 1, 32'h1000_0009, 4'b0010));
    vecs.push_back(mk("bp_stall1",   1, 4'b0010, 4'b0000, 1, 28'hA, 4'b0010, 1, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("bp_stall2",   1, 4'b0010, 4'b0000, 1, 28'hA, 4'b0010, 1, 0, 32'h0, 4'b0000));
    vecs.push_back(mk("bp_w2",       1, 4'b0010, 4'b0000, 0, 28'hA, 4'b0010, 1, 1, 32'h1000_000A, 4'b0010));
    vecs.push_back(mk("bp_w3",       1, 4'b0010, 4'b0010, 0, 28'hB, 4'b0010, 1, 1, 32'h1000_000B, 4'b0010));
    vecs.push_back(mk("bp_done",     1, 4'b0000, 4'b0000, 1, 28'h0, 4'b0000, 0, 0, 32'h0, 4'b0000));

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].name, vecs[k].rst, vecs[k].valid, vecs[k].last, vecs[k].full, vecs[k].word,
           vecs[k].exp_grant, vecs[k].exp_busy, vecs[k].exp_wr, vecs[k].exp_wdata, vecs[k].exp_ready);
    end

    // rr_ptr is now 2: start a burst on producer 2, then reset during its second beat
    step("mr_idle",  1, 4'b1111, 4'b0000, 0, 28'h20, 4'b0000, 0, 0, 32'h0, 4'b0000);
    step("mr_beat1", 1, 4'b1111, 4'b0000, 0, 28'h21, 4'b0100, 1, 1, 32'h2000_0021, 4'b0100);
    step("mr_beat2", 1, 4'b1111, 4'b0000, 0, 28'h22, 4'b0100, 1, 1, 32'h2000_0022, 4'b0100);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mr_abort", 4'b0000, 0, 0, 32'h0, 4'b0000);
    step("mr_hold",  0, 4'b1111, 4'b0000, 0, 28'h23, 4'b0000, 0, 0, 32'h0, 4'b0000);
    step("mr_relse", 1, 4'b1111, 4'b0000, 0, 28'h24, 4'b0000, 0, 0, 32'h0, 4'b0000);

    // sustained requests: grants 0,1,2,3,0, four writes each, one idle cycle between
    word_cnt = 28'h100;
    for (int b = 0; b < 5; b++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (b % 4);
      if (b > 0) begin
        step($sformatf("rr_gap%0d", b), 1, 4'b1111, 4'b0000, 0, word_cnt,
             4'b0000, 0, 0, 32'h0, 4'b0000);
        word_cnt = word_cnt + 1;
      end
      for (int w = 0; w < 4; w++) begin
        step($sformatf("rr_b%0d_w%0d", b, w), 1, 4'b1111, 4'b0000, 0, word_cnt,
             exp_g, 1, 1, {4'(b % 4), word_cnt}, exp_g);
        word_cnt = word_cnt + 1;
      end
    end
    step("rr_end", 1, 4'b0000, 4'b0000, 0, 28'h0, 4'b0000, 0, 0, 32'h0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter that shares the single write port of the `fifo` block between `NREQ` independent producers. Each producer offers words through a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` words and drives the FIFO `wr_en`/`wdata`. It observes `full_flag` so that no write is issued to a full FIFO and no producer word is lost.

## Interface
- `WIDTH`, 32, data word width; matches the FIFO `WIDTH`.
- `NREQ`, 4, number of producers; 2..8.
- `MAX_BURST`, 4, maximum words per grant; 1..16.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  producer i has a word on its data lane.
- `req_data`  in  NREQ*WIDTH  producer i data on bits [i*WIDTH +: WIDTH].
- `req_last`  in  NREQ  current word is the last of producer i's burst.
- `req_ready`  out  NREQ  word of producer i accepted this cycle when valid&ready.
- `full_flag`  in  1  FIFO full.
- `wr_en`  out  1  FIFO write enable.
- `wdata`  out  WIDTH  FIFO write data.
- `grant`  out  NREQ  one-hot current owner; 0 when idle (registered).
- `busy`  out  1  high while in BURST.

## Operation
- FSM states: IDLE, BURST. Registers: `state`, `owner` (index), `grant`, `rr_ptr` (clog2(NREQ) bits), `beats` (counts 0..MAX_BURST).
- IDLE: if any `req_valid`, the arbiter selects the first i with `req_valid[i]`, searching i = rr_ptr, rr_ptr+1, … and wrapping modulo NREQ. It then sets `owner`=i, `grant`=1<<i, `beats`=0, and goes to BURST. Otherwise it stays in IDLE.
- BURST: `req_ready[owner]` = !`full_flag`; all other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[owner]` & `req_ready[owner]`.
  - During a transfer, `wr_en`=1 and `wdata`=`req_data[owner]`; `beats` increments.
  - `wr_en` and `wdata` are combinational from the registered `state`/`owner`, so a write never occurs while `full_flag`=1.
  - Outside a transfer, `wr_en`=0 and `wdata`=0.
- Release from BURST to IDLE happens at the edge where any of the following holds:
  - (a) a transfer with `req_last[owner]`=1;
  - (b) a transfer that makes `beats`==MAX_BURST;
  - (c) `req_valid[owner]`=0 (no transfer).
- On release, `rr_ptr` ← (owner+1) mod NREQ, `grant` ← 0, `beats` ← 0.
- `full_flag`=1 in BURST stalls: `grant`, `owner` and `beats` are held, and release is not triggered unless (c) applies.
- IDLE: all `req_ready`=0, `wr_en`=0.
- Reset values: `state`=IDLE, `grant`=0, `rr_ptr`=0, `beats`=0, so `req_ready`=0, `wr_en`=0, `wdata`=0, `busy`=0.
- Reset asserted mid-burst: the in-flight burst is abandoned and no write is issued while `rst`=0. Words not yet accepted remain the producer's responsibility.
- Producers may change `req_valid` at any time. The arbiter never takes a word without a `req_ready` handshake.

## Timing
- Arbitration latency: `req_valid` sampled high in IDLE at edge k → `grant`/`busy` high after edge k → first write at edge k+1 if not full.
- Throughput inside a burst: 1 word/cycle.
- Each release costs exactly one IDLE cycle before the next grant, including when the same requester continues. Maximum sustained rate is therefore MAX_BURST/(MAX_BURST+1).
- Round-robin fairness: any requester holding `req_valid` continuously is granted within NREQ-1 other bursts.
- Concurrent requests in IDLE are resolved only by `rr_ptr` order. Requests arriving during BURST wait for the next IDLE.
- `rr_ptr` wraps from NREQ-1 to 0.

## Test plan
- **Reset:** hold `rst`=0 with all `req_valid`=1 → `grant`=0, `wr_en`=0, `req_ready`=0. Release reset → requester 0 granted one cycle later.
- **Single producer:** producer 2 sends A0000001..A0000003 with `req_last` on the third word, FIFO empty. Required response:
  - writes A0000001, A0000002, A0000003 on consecutive cycles;
  - release after the third write;
  - `rr_ptr`=3.
- **Round-robin:** all four producers continuously valid with distinct data and no `req_last`, MAX_BURST=4. Required response:
  - grants go 0,1,2,3,0;
  - each burst is exactly 4 writes;
  - one idle cycle between bursts.
- **Full back-pressure:** 7 words are pre-written to an 8-deep FIFO, then producer 1 offers 3 words. Required response:
  - 1 write occurs;
  - `req_ready` drops while `full_flag`=1 and no `wr_en` is issued;
  - after 2 FIFO reads, the remaining 2 words are written in order with nothing lost or duplicated.
- **Producer drop:** producer 3 is granted, writes 1 word, then deasserts `req_valid`. Required response:
  - release at that edge;
  - producer 0 (waiting) is granted next.
- **Mid-burst reset:** `rst`=0 during the 2nd beat of a burst → `wr_en`=0 immediately. After reset, `rr_ptr`=0 and arbitration restarts from requester 0.
